write_select_decoder: RTL
=========================

WRITE_SELECT_DECODER -- requirements
Module: write_select_decoder

Interface
REQ-001 SHALL provide the following parameters:
- ADDR_W, default 5, address width; decoded vector width is 2**ADDR_W.
- ZERO_PROTECT, default 1, when 1 address 0 is never selected (hard-wired zero register).
- CNT_W, default 8, conflict counter width.

REQ-002 SHALL provide the following ports:
- CLK  input  1  sole clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ADDR0  input  ADDR_W  write-port 0 address.
- EN0  input  1  write-port 0 enable.
- ADDR1  input  ADDR_W  write-port 1 address.
- EN1  input  1  write-port 1 enable.
- CLR_CNT  input  1  synchronous clear of CONFLICT_CNT.
- OUT0  output  2**ADDR_W  registered one-hot (or all-zero) select for port 0.
- OUT1  output  2**ADDR_W  registered one-hot (or all-zero) select for port 1.
- VALID  output  1  registered; high when OUT0 or OUT1 has any bit set.
- CONFLICT  output  1  registered one-cycle flag: both ports targeted the same address.
- CONFLICT_CNT  output  CNT_W  saturating count of conflict cycles.

Function
REQ-003 SHALL have one cycle of latency: inputs sampled at rising edge N appear on all outputs after edge N and are held until edge N+1.
REQ-004 SHALL qualify port p (p = 0, 1) as live when ENp=1 and not (ZERO_PROTECT=1 and ADDRp=0).
REQ-005 SHALL drive OUTp with exactly bit ADDRp set when port p is live and not suppressed; otherwise OUTp SHALL be all zero.
REQ-006 SHALL detect a conflict when both ports are live and ADDR0 == ADDR1.
REQ-007 On a conflict, port 1 SHALL win: OUT1 one-hot at the address, OUT0 all zero, CONFLICT=1 for that cycle.
REQ-008 SHALL NOT flag a conflict when either port is not live, including the case ADDR0 == ADDR1 == 0 with ZERO_PROTECT=1.
REQ-009 SHALL set VALID as the registered OR of all bits of the next OUT0 and OUT1.
REQ-010 SHALL increment CONFLICT_CNT by 1 on each edge where a conflict is detected, saturating at 2**CNT_W-1 with no wrap-around.
REQ-011 CLR_CNT=1 at an edge SHALL load CONFLICT_CNT with 0; when it coincides with a conflict, clear wins (result 0), but CONFLICT still pulses.
REQ-012 SHALL treat ports with differing live addresses as independent; OUT0 and OUT1 together then hold two set bits.
REQ-013 With ZERO_PROTECT=0, address 0 SHALL decode as any other address, including for conflict detection.
REQ-014 SHALL be correct for any ADDR_W from 1 to 6 and any CNT_W of 1 or more; there is no combinational path from inputs to outputs.

Reset
REQ-015 RESET=1 SHALL immediately, without waiting for CLK, force OUT0=0, OUT1=0, VALID=0, CONFLICT=0 and CONFLICT_CNT=0.
REQ-016 RESET asserted mid-operation SHALL discard the in-flight decode; the first edge after RESET deasserts SHALL reflect only the inputs sampled at that edge.
REQ-017 Outputs SHALL hold their reset values while RESET=1, regardless of CLK or input activity.

Verification
REQ-018 Single port: EN0=1, ADDR0=7, EN1=0 -> next cycle OUT0=0x00000080, OUT1=0, VALID=1, CONFLICT=0.
REQ-019 Conflict: EN0=EN1=1, ADDR0=ADDR1=19 -> OUT1=0x00080000, OUT0=0, CONFLICT=1, CONFLICT_CNT increments by 1.
REQ-020 Zero protect: EN0=EN1=1, ADDR0=ADDR1=0, ZERO_PROTECT=1 -> OUT0=OUT1=0, VALID=0, CONFLICT=0, count unchanged; the same stimulus with ZERO_PROTECT=0 -> OUT1=0x1, CONFLICT=1.
REQ-021 Saturation and clear: CNT_W=2 with 5 consecutive conflicts -> CONFLICT_CNT reads 1, 2, 3, 3, 3; then CLR_CNT=1 together with a conflict -> CONFLICT_CNT=0, CONFLICT=1.
REQ-022 Async reset: assert RESET between edges while OUT0=0x4 and CONFLICT_CNT=2 -> all outputs 0 before the next CLK edge; after release, EN1=1, ADDR1=31 -> OUT1=0x80000000.
REQ-023 Exhaustive sweep: all {ADDR0, EN0, ADDR1, EN1} combinations at ADDR_W=3 -> every output matches a reference model delayed by one cycle.

Source files
------------

// File: rtl/write_select_decoder.sv
// -----------------------------------------------------------------------------
// write_select_decoder
//
// Turns two register-file write ports (address + enable) into registered
// one-hot write-select vectors. When both ports hit the same live address in
// the same cycle, port 1 wins and the collision is flagged and counted.
//
// Parameters
//   ADDR_W        address width; select vectors are 2**ADDR_W bits wide
//   ZERO_PROTECT  when non-zero, address 0 is never selected (hard-wired zero)
//   CNT_W         width of the saturating conflict counter
//
// Ports
//   CLK           clock, all state updates on the rising edge
//   RESET         asynchronous active-high reset
//   ADDR0/EN0     write port 0 address / enable
//   ADDR1/EN1     write port 1 address / enable
//   CLR_CNT       synchronous clear of CONFLICT_CNT (wins over increment)
//   OUT0/OUT1     registered one-hot (or all-zero) selects
//   VALID         registered: OUT0 or OUT1 has any bit set
//   CONFLICT      registered one-cycle collision flag
//   CONFLICT_CNT  saturating count of collision cycles
// -----------------------------------------------------------------------------
module write_select_decoder #(
    parameter int ADDR_W       = 5,
    parameter int ZERO_PROTECT = 1,
    parameter int CNT_W        = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [ADDR_W-1:0]      ADDR0,
    input  logic                   EN0,
    input  logic [ADDR_W-1:0]      ADDR1,
    input  logic                   EN1,
    input  logic                   CLR_CNT,
    output logic [2**ADDR_W-1:0]   OUT0,
    output logic [2**ADDR_W-1:0]   OUT1,
    output logic                   VALID,
    output logic                   CONFLICT,
    output logic [CNT_W-1:0]       CONFLICT_CNT
);

    localparam int              N       = 2**ADDR_W;
    localparam bit              ZP      = (ZERO_PROTECT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             live0;
    logic             live1;
    logic             conflict_next;
    logic             valid_next;
    logic [N-1:0]     out0_next;
    logic [N-1:0]     out1_next;

    logic [N-1:0]     out0_reg;
    logic [N-1:0]     out1_reg;
    logic             valid_reg;
    logic             conflict_reg;
    logic [CNT_W-1:0] cnt_reg;

    // A port is live when enabled and not aimed at the protected zero register.
    assign live0 = EN0 && !(ZP && (ADDR0 == '0));
    assign live1 = EN1 && !(ZP && (ADDR1 == '0));

    // Only live ports can collide, so a write to the zero register never
    // counts as a conflict while it is protected.
    assign conflict_next = live0 && live1 && (ADDR0 == ADDR1);

    // Per-bit decode. Port 0 is suppressed on a collision so port 1 wins.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dec
            assign out0_next[gi] = live0 && !conflict_next && (ADDR0 == ADDR_W'(gi));
            assign out1_next[gi] = live1 && (ADDR1 == ADDR_W'(gi));
        end
    endgenerate

    assign valid_next = (|out0_next) || (|out1_next);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out0_reg     <= '0;
            out1_reg     <= '0;
            valid_reg    <= 1'b0;
            conflict_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            out0_reg     <= out0_next;
            out1_reg     <= out1_next;
            valid_reg    <= valid_next;
            conflict_reg <= conflict_next;
            // Clear has priority; the CONFLICT flag still pulses regardless.
            if (CLR_CNT) begin
                cnt_reg <= '0;
            end else if (conflict_next && (cnt_reg != CNT_MAX)) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign OUT0         = out0_reg;
    assign OUT1         = out1_reg;
    assign VALID        = valid_reg;
    assign CONFLICT     = conflict_reg;
    assign CONFLICT_CNT = cnt_reg;

endmodule
